// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register map, bit indices and interrupt codes for timer_intr_ctrl
// Purpose: shared definitions for the machine timer / external interrupt peripheral.
// Ports: none (package).
package timer_pkg;

  localparam logic [7:0] ADDR_MTIME_LO    = 8'h00;
  localparam logic [7:0] ADDR_MTIME_HI    = 8'h04;
  localparam logic [7:0] ADDR_MTIMECMP_LO = 8'h08;
  localparam logic [7:0] ADDR_MTIMECMP_HI = 8'h0C;
  localparam logic [7:0] ADDR_EXT_CTRL    = 8'h10;
  localparam logic [7:0] ADDR_EXT_COUNT   = 8'h14;

  localparam int EXT_PEND_BIT = 0;
  localparam int EXT_EN_BIT   = 1;

  typedef enum logic [3:0] {
    INTR_NONE  = 4'd0,
    INTR_TIMER = 4'd1,
    INTR_EXT   = 4'd2
  } intr_code_e;

endpackage

// File: rtl/ext_irq_sync.sv
// rtl/ext_irq_sync.sv - two-flop synchronizer with rising-edge detector
// Purpose: brings the asynchronous external request into clk and emits a 1-cycle pulse per rising edge.
// Ports:
//   clk      in  1  clock
//   rst      in  1  synchronous active-high reset
//   async_in in  1  asynchronous request line
//   rise     out 1  one-cycle pulse on a synchronized rising edge
module ext_irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/timer_intr_ctrl.sv
// rtl/timer_intr_ctrl.sv - 64-bit machine timer plus latched external interrupt, bus-mapped
// Purpose: produces the registered interrupt code (0 none, 1 timer, 2 external) for the CSR file.
// Build option: TIMER_PRESCALE_EN enables a PRESCALE-cycle tick divider for mtime.
// Ports:
//   clk       in  1   clock
//   rst       in  1   synchronous active-high reset
//   cs        in  1   peripheral select
//   wr        in  1   1 = write, 0 = read
//   addr      in  8   byte offset, addr[1:0] ignored
//   wdata     in  32  write data
//   rdata     out 32  combinational read data, 0 unless cs & !wr
//   ext_irq_i in  1   asynchronous external interrupt request
//   interrupt out 4   registered interrupt code
module timer_intr_ctrl
  import timer_pkg::*;
#(
  parameter int PRESCALE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        wr,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        ext_irq_i,
  output logic [3:0]  interrupt
);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        pending;
  logic        enable;
  logic [7:0]  count;
  intr_code_e  intr_q;
  intr_code_e  intr_d;
  logic        ext_rise;
  logic        tick;

  logic [7:0]  word_addr;
  logic [1:0]  unused_addr_bits;
  logic        wr_en;
  logic        wr_mtime_lo;
  logic        wr_mtime_hi;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        wr_ctrl;
  logic        timer_pend;

  assign word_addr        = {addr[7:2], 2'b00};
  assign unused_addr_bits = addr[1:0];
  assign wr_en            = cs & wr;
  assign wr_mtime_lo      = wr_en && (word_addr == ADDR_MTIME_LO);
  assign wr_mtime_hi      = wr_en && (word_addr == ADDR_MTIME_HI);
  assign wr_cmp_lo        = wr_en && (word_addr == ADDR_MTIMECMP_LO);
  assign wr_cmp_hi        = wr_en && (word_addr == ADDR_MTIMECMP_HI);
  assign wr_ctrl          = wr_en && (word_addr == ADDR_EXT_CTRL);

  ext_irq_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (ext_irq_i),
    .rise     (ext_rise)
  );

`ifdef TIMER_PRESCALE_EN
  logic [31:0] div;

  assign tick = (div == 32'(PRESCALE - 1));

  // Writing either mtime half restarts the divider so the written value
  // gets a full PRESCALE period before its first increment.
  always_ff @(posedge clk) begin
    if (rst || wr_mtime_lo || wr_mtime_hi || tick) begin
      div <= '0;
    end else begin
      div <= div + 32'd1;
    end
  end
`else
  logic [31:0] unused_prescale;

  assign unused_prescale = 32'(PRESCALE);
  assign tick            = 1'b1;
`endif

  assign timer_pend = (mtime >= mtimecmp);

  always_comb begin
    intr_d = INTR_NONE;
    if (pending && enable) begin
      intr_d = INTR_EXT;
    end else if (timer_pend) begin
      intr_d = INTR_TIMER;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime    <= '0;
      mtimecmp <= '1;
      pending  <= 1'b0;
      enable   <= 1'b0;
      count    <= '0;
      intr_q   <= INTR_NONE;
    end else begin
      // A bus write replaces the increment; the other half keeps its value.
      if (wr_mtime_lo) begin
        mtime[31:0] <= wdata;
      end else if (wr_mtime_hi) begin
        mtime[63:32] <= wdata;
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end

      if (wr_cmp_lo) mtimecmp[31:0]  <= wdata;
      if (wr_cmp_hi) mtimecmp[63:32] <= wdata;

      // A new edge must never be lost to a concurrent clear.
      if (ext_rise) begin
        pending <= 1'b1;
      end else if (wr_ctrl && wdata[EXT_PEND_BIT]) begin
        pending <= 1'b0;
      end

      if (wr_ctrl) enable <= wdata[EXT_EN_BIT];

      if (ext_rise && (count != 8'hFF)) count <= count + 8'd1;

      intr_q <= intr_d;
    end
  end

  assign interrupt = intr_q;

  always_comb begin
    rdata = '0;
    if (cs && !wr) begin
      case (word_addr)
        ADDR_MTIME_LO:    rdata = mtime[31:0];
        ADDR_MTIME_HI:    rdata = mtime[63:32];
        ADDR_MTIMECMP_LO: rdata = mtimecmp[31:0];
        ADDR_MTIMECMP_HI: rdata = mtimecmp[63:32];
        ADDR_EXT_CTRL: begin
          rdata[EXT_PEND_BIT] = pending;
          rdata[EXT_EN_BIT]   = enable;
        end
        ADDR_EXT_COUNT:   rdata[7:0] = count;
        default:          rdata = '0;
      endcase
    end
  end

endmodule
